// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state encodings and operand width.
package operand_loader_pkg;

    localparam int unsigned OperandWidth = 4;

    typedef enum logic [1:0] {
        LoadA = 2'b00,
        LoadB = 2'b01,
        Show  = 2'b10
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton to single-cycle press pulse: 2-flop synchroniser, counting debouncer and
// rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btnRaw,
    output logic pulse
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1Q;
    logic            sync2Q;
    logic            levelQ;
    logic            levelPrevQ;
    logic            pulseQ;
    logic [CntW-1:0] cntQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1Q     <= 1'b0;
            sync2Q     <= 1'b0;
            levelQ     <= 1'b0;
            levelPrevQ <= 1'b0;
            pulseQ     <= 1'b0;
            cntQ       <= '0;
        end else begin
            sync1Q     <= btnRaw;
            sync2Q     <= sync1Q;
            levelPrevQ <= levelQ;
            pulseQ     <= levelQ & ~levelPrevQ;
            // Flip on the last differing cycle, so the count never exceeds CntLast.
            if (sync2Q == levelQ) begin
                cntQ <= '0;
            end else if (cntQ >= CntLast) begin
                levelQ <= sync2Q;
                cntQ   <= '0;
            end else begin
                cntQ <= cntQ + CntW'(1);
            end
        end
    end

    assign pulse = pulseQ;

endmodule

// File: rtl/operand_loader.sv
// Loads two operands from switches on debounced button presses, presents them to an external
// magnitude comparator and registers its result while both operands are valid.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OperandWidth-1:0] sw,
    input  logic                    load_btn,
    input  logic                    clear_btn,
    input  logic                    eq_in,
    input  logic                    gta_in,
    input  logic                    gtb_in,
    output logic [OperandWidth-1:0] op_a,
    output logic [OperandWidth-1:0] op_b,
    output logic                    valid,
    output logic [1:0]              state_code,
    output logic                    res_eq,
    output logic                    res_gta,
    output logic                    res_gtb
);

    logic loadPulse;
    logic clearPulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) loadDeb (
        .clk   (clk),
        .rst   (rst),
        .btnRaw(load_btn),
        .pulse (loadPulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) clearDeb (
        .clk   (clk),
        .rst   (rst),
        .btnRaw(clear_btn),
        .pulse (clearPulse)
    );

    state_e                  stateQ, stateD;
    logic [OperandWidth-1:0] opAQ, opAD;
    logic [OperandWidth-1:0] opBQ, opBD;
    logic [2:0]              resQ, resD;
    logic                    validInt;

    assign validInt = (stateQ == Show);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= LoadA;
            opAQ   <= '0;
            opBQ   <= '0;
            resQ   <= '0;
        end else begin
            stateQ <= stateD;
            opAQ   <= opAD;
            opBQ   <= opBD;
            resQ   <= resD;
        end
    end

    always_comb begin
        stateD = stateQ;
        opAD   = opAQ;
        opBD   = opBQ;
        resD   = validInt ? {eq_in, gta_in, gtb_in} : resQ;
        if (clearPulse) begin
            // Clear has priority over a coincident load.
            stateD = LoadA;
            opAD   = '0;
            opBD   = '0;
            resD   = '0;
        end else begin
            case (stateQ)
                LoadA: begin
                    if (loadPulse) begin
                        opAD   = sw;
                        stateD = LoadB;
                    end
                end
                LoadB: begin
                    if (loadPulse) begin
                        opBD   = sw;
                        stateD = Show;
                    end
                end
                Show: begin
                    if (loadPulse) begin
                        opAD   = sw;
                        stateD = LoadB;
                    end
                end
                default: begin
                    stateD = LoadA;
                    opAD   = '0;
                    opBD   = '0;
                    resD   = '0;
                end
            endcase
        end
    end

    assign op_a       = opAQ;
    assign op_b       = opBQ;
    assign valid      = validInt;
    assign state_code = stateQ;
    assign res_eq     = resQ[2];
    assign res_gta    = resQ[1];
    assign res_gtb    = resQ[0];

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a behavioural comparator; expected outputs are
// queued when stimulus is applied and popped once the press has settled.
module tb_operand_loader;
    import operand_loader_pkg::*;

    localparam int unsigned Db = 4;
    localparam int unsigned HoldCycles = Db + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'h0;
    logic       loadBtn = 1'b0;
    logic       clearBtn = 1'b0;
    logic       eqIn, gtaIn, gtbIn;
    logic [3:0] opA, opB;
    logic       valid;
    logic [1:0] stateCode;
    logic       resEq, resGta, resGtb;

    operand_loader #(
        .DEBOUNCE_CYCLES(Db)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .load_btn  (loadBtn),
        .clear_btn (clearBtn),
        .eq_in     (eqIn),
        .gta_in    (gtaIn),
        .gtb_in    (gtbIn),
        .op_a      (opA),
        .op_b      (opB),
        .valid     (valid),
        .state_code(stateCode),
        .res_eq    (resEq),
        .res_gta   (resGta),
        .res_gtb   (resGtb)
    );

    assign eqIn  = (opA == opB);
    assign gtaIn = (opA > opB);
    assign gtbIn = (opA < opB);

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [1:0] st;
        logic       eq;
        logic       gta;
        logic       gtb;
    } exp_t;

    exp_t sbQ[$];
    int   tests = 0;
    int   failures = 0;
    int   stChanges = 0;
    logic [1:0] lastSt = 2'b00;

    task automatic tick();
        @(posedge clk);
        #1;
        if (stateCode !== lastSt) stChanges++;
        lastSt = stateCode;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input logic [3:0] a, input logic [3:0] b, input logic v,
                           input logic [1:0] st, input logic eq, input logic gta,
                           input logic gtb);
        exp_t e;
        e.a = a; e.b = b; e.v = v; e.st = st; e.eq = eq; e.gta = gta; e.gtb = gtb;
        sbQ.push_back(e);
    endtask

    task automatic checkOut(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            tests++;
            failures++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            cmp({tag, ".op_a"}, {4'h0, opA}, {4'h0, e.a});
            cmp({tag, ".op_b"}, {4'h0, opB}, {4'h0, e.b});
            cmp({tag, ".valid"}, {7'h0, valid}, {7'h0, e.v});
            cmp({tag, ".state"}, {6'h0, stateCode}, {6'h0, e.st});
            cmp({tag, ".res"}, {5'h0, resEq, resGta, resGtb}, {5'h0, e.eq, e.gta, e.gtb});
        end
    endtask

    task automatic press(input logic l, input logic c);
        loadBtn  = l;
        clearBtn = c;
        repeat (HoldCycles) tick();
        loadBtn  = 1'b0;
        clearBtn = 1'b0;
        repeat (HoldCycles) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        pushExp(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOut("reset");

        // A then 3; result appears one cycle after valid rises
        sw = 4'hA;
        pushExp(4'hA, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        checkOut("loadA");
        sw = 4'h3;
        loadBtn = 1'b1;
        cyc = 0;
        while (valid !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        cmp("validRiseInTime", {7'h0, valid}, 8'h01);
        cmp("resBeforeSample", {5'h0, resEq, resGta, resGtb}, 8'h00);
        tick();
        cmp("resAfterSample", {5'h0, resEq, resGta, resGtb}, 8'h02);
        repeat (HoldCycles) tick();
        loadBtn = 1'b0;
        repeat (HoldCycles) tick();
        pushExp(4'hA, 4'h3, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        checkOut("loadB");

        pushExp(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        checkOut("clearInShow");

        // Bouncing load button yields exactly one pulse
        sw = 4'h6;
        stChanges = 0;
        for (int i = 0; i < 10; i++) begin
            loadBtn = (i % 2 == 0);
            repeat (2) tick();
        end
        cmp("bounceNoPulse", {4'h0, opA}, 8'h00);
        loadBtn = 1'b1;
        repeat (10) tick();
        loadBtn = 1'b0;
        repeat (HoldCycles) tick();
        cmp("bounceOnePulse", stChanges[7:0], 8'h01);
        pushExp(4'h6, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOut("bounce");

        // 5 == 5, then reload A in SHOW; results hold while valid is low
        press(1'b0, 1'b1);
        sw = 4'h5;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        pushExp(4'h5, 4'h5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOut("equal");
        sw = 4'h2;
        pushExp(4'h2, 4'h5, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        checkOut("reloadInShow");

        // Coincident load and clear in LOAD_B
        sw = 4'h9;
        pushExp(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1);
        checkOut("clearWins");

        // Reset mid-debounce with button held
        sw = 4'h7;
        press(1'b1, 1'b0);
        sw = 4'h9;
        loadBtn = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pushExp(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOut("midReset");
        stChanges = 0;
        cyc = 0;
        while (stateCode !== 2'b01 && cyc < 30) begin
            tick();
            cyc++;
        end
        cmp("pulseAfterReset", {7'h0, (cyc >= int'(Db) && cyc < 30)}, 8'h01);
        repeat (10) tick();
        loadBtn = 1'b0;
        repeat (HoldCycles) tick();
        cmp("resetOnePulse", stChanges[7:0], 8'h01);
        pushExp(4'h9, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOut("heldThroughReset");

        // Illegal state recovers with everything cleared
        sw = 4'h4;
        pushExp(4'h9, 4'h4, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0);
        checkOut("preIllegal");
        force dut.stateQ = state_e'(2'b11);
        #1;
        release dut.stateQ;
        cmp("illegalValid", {7'h0, valid}, 8'h00);
        tick();
        pushExp(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOut("illegalRecover");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
